// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared ALU. It grants one requester at a time,
// registers the operands, waits one cycle for the ALU, then presents the
// result to the consumer with a valid/ready handshake.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1   // 1: round-robin between ports, 0: port 0 always wins
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_op,
    input  logic signed [31:0] req0_x,
    input  logic signed [31:0] req0_y,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_op,
    input  logic signed [31:0] req1_x,
    input  logic signed [31:0] req1_y,
    output logic [3:0]         alu_op,
    output logic [31:0]        alu_x,
    output logic [31:0]        alu_y,
    input  logic [31:0]        alu_result,
    input  logic               alu_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_flag,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_flag_q, rsp_flag_d;

    logic        can_accept;
    logic        gnt_id;
    logic        accept;

    // Grant selection: a lone valid port wins; on contention use prio (or port 0)
    always_comb begin
        can_accept = (state_q == IDLE) ||
                     ((state_q == RESP) && rsp_valid_q && rsp_ready);
        if (req0_valid && req1_valid) begin
            gnt_id = RR_EN ? prio_q : 1'b0;
        end else begin
            gnt_id = req1_valid;
        end
        // Readies are gated by rst_n so nothing is accepted while in reset
        req0_ready = rst_n && can_accept && req0_valid && !gnt_id;
        req1_ready = rst_n && can_accept && req1_valid &&  gnt_id;
        accept     = req0_ready || req1_ready;
    end

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had one full cycle on the registered operands
                rsp_result_d = alu_result;
                rsp_flag_d   = alu_flag;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand capture on any handshake; otherwise the registers hold
        if (accept) begin
            op_d   = gnt_id ? req1_op : req0_op;
            x_d    = gnt_id ? req1_x  : req0_x;
            y_d    = gnt_id ? req1_y  : req0_y;
            id_d   = gnt_id;
            prio_d = ~gnt_id;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            op_q         <= 4'b0000;
            x_q          <= 32'd0;
            y_q          <= 32'd0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = (state_q != IDLE);

endmodule
